// File: rtl/branch_update_queue.sv
// In-order queue of predicted conditional branches. It retires the oldest entry on resolve,
// drives the predictor training port and squashes younger wrong-path entries on a mispredict.
module branch_update_queue #(
    parameter int DEPTH     = 4,
    parameter int PC_WIDTH  = 16,
    parameter int CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [PC_WIDTH-1:0]      push_pc,
    input  logic                     push_pred,
    input  logic                     resolve,
    input  logic                     resolve_taken,
    input  logic                     flush,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic                     write_enabled,
    output logic                     outcome,
    output logic [PC_WIDTH-1:0]      pc_bits_write,
    output logic                     mispredict,
    output logic [CNT_WIDTH-1:0]     mispredict_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_mem [DEPTH];
    logic [DEPTH-1:0]    pred_mem;

    logic [PTR_W-1:0] head, tail, head_nxt;
    logic [OCC_W-1:0] occ;
    logic             resolve_valid, mis, push_ok;

    assign occupancy = occ;
    assign full      = (occ == OCC_W'(DEPTH));
    assign empty     = (occ == '0);

    // A resolve against an empty queue never touches the entry being pushed in the same cycle.
    assign resolve_valid = resolve && !empty;
    assign mis           = resolve_valid && (resolve_taken != pred_mem[head]);
    assign push_ok       = push && !flush && !mis && (!full || resolve_valid);
    assign head_nxt      = head + PTR_W'(resolve_valid);

    // NOTE: the entry storage has no reset; pointers and occupancy alone define which slots are live.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) begin
            pc_mem[tail]   <= push_pc;
            pred_mem[tail] <= push_pred;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head             <= '0;
            tail             <= '0;
            occ              <= '0;
            write_enabled    <= 1'b0;
            outcome          <= 1'b0;
            pc_bits_write    <= '0;
            mispredict       <= 1'b0;
            mispredict_count <= '0;
        end else begin
            write_enabled <= resolve_valid;
            mispredict    <= mis;
            if (resolve_valid) begin
                outcome       <= resolve_taken;
                pc_bits_write <= pc_mem[head];
            end
            if (mis && (mispredict_count != '1))
                mispredict_count <= mispredict_count + CNT_WIDTH'(1);

            head <= head_nxt;
            // Squash or flush: everything behind the (possibly popped) head is wrong-path.
            if (flush || mis) begin
                tail <= head_nxt;
                occ  <= '0;
            end else begin
                tail <= tail + PTR_W'(push_ok);
                occ  <= occ + OCC_W'(push_ok) - OCC_W'(resolve_valid);
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: a queue-based reference model feeds a scoreboard
// of expected training writes, which a monitor process pops whenever write_enabled is seen.
module tb_branch_update_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 16;
    localparam int CNT_W = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset, push, push_pred, resolve, resolve_taken, flush;
    logic [PC_W-1:0]  push_pc;
    logic             full, empty, write_enabled, outcome, mispredict;
    logic [$clog2(DEPTH):0] occupancy;
    logic [PC_W-1:0]  pc_bits_write;
    logic [CNT_W-1:0] mispredict_count;

    branch_update_queue #(.DEPTH(DEPTH), .PC_WIDTH(PC_W), .CNT_WIDTH(CNT_W)) dut (
        .clk(clk), .reset(reset), .push(push), .push_pc(push_pc), .push_pred(push_pred),
        .resolve(resolve), .resolve_taken(resolve_taken), .flush(flush),
        .full(full), .empty(empty), .occupancy(occupancy),
        .write_enabled(write_enabled), .outcome(outcome), .pc_bits_write(pc_bits_write),
        .mispredict(mispredict), .mispredict_count(mispredict_count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [PC_W-1:0] pc; logic pred; } entry_t;
    typedef struct { logic [PC_W-1:0] pc; logic taken; logic mis; } train_t;

    entry_t model_q[$];
    train_t exp_q[$];
    int     model_count = 0;
    int     checks = 0;
    int     errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every training write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (write_enabled === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_write", 32'(write_enabled), 32'd0);
            end else begin
                train_t e;
                e = exp_q.pop_front();
                check("train_pc", 32'(pc_bits_write), 32'(e.pc));
                check("train_outcome", 32'(outcome), 32'(e.taken));
                check("train_mispredict", 32'(mispredict), 32'(e.mis));
            end
        end else if (mispredict !== 1'b0) begin
            check("mispredict_without_write", 32'(mispredict), 32'd0);
        end
    end

    task automatic check_state();
        check("occupancy", 32'(occupancy), 32'(model_q.size()));
        check("full", 32'(full), 32'(model_q.size() == DEPTH));
        check("empty", 32'(empty), 32'(model_q.size() == 0));
        check("mispredict_count", 32'(mispredict_count), 32'(model_count));
    endtask

    // One clock cycle: drive inputs (called right after a negedge), update the model, check state.
    task automatic cycle(input logic p, input logic [PC_W-1:0] pc, input logic pd,
                         input logic r, input logic t, input logic f, input logic rst);
        logic rv, mis;
        push = p; push_pc = pc; push_pred = pd;
        resolve = r; resolve_taken = t; flush = f; reset = rst;
        if (rst) begin
            model_q.delete();
            model_count = 0;
        end else begin
            rv  = r && (model_q.size() > 0);
            mis = 1'b0;
            if (rv) begin
                entry_t h;
                h   = model_q.pop_front();
                mis = (t != h.pred);
                exp_q.push_back('{pc: h.pc, taken: t, mis: mis});
                if (mis) begin
                    model_q.delete();
                    if (model_count < CNT_MAX) model_count++;
                end
            end
            if (f) model_q.delete();
            else if (p && !mis && model_q.size() < DEPTH) model_q.push_back('{pc: pc, pred: pd});
        end
        @(negedge clk);
        check_state();
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_push(input logic [PC_W-1:0] pc, input logic pd);
        cycle(1'b1, pc, pd, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_resolve(input logic t);
        cycle(1'b0, '0, 1'b0, 1'b1, t, 1'b0, 1'b0);
    endtask

    initial begin
        logic [PC_W-1:0] fill_pc [4];
        logic [3:0]      fill_pred;
        fill_pc[0] = 16'h0104; fill_pc[1] = 16'h0208; fill_pc[2] = 16'h030C; fill_pc[3] = 16'h0410;
        fill_pred = 4'b1101;  // index 0 is the LSB: preds 1,0,1,1

        push = 0; push_pc = '0; push_pred = 0; resolve = 0; resolve_taken = 0; flush = 0; reset = 1;
        @(negedge clk);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("reset_write_enabled", 32'(write_enabled), 32'd0);
        check("reset_outcome", 32'(outcome), 32'd0);
        check("reset_pc_bits_write", 32'(pc_bits_write), 32'd0);
        check("reset_mispredict", 32'(mispredict), 32'd0);

        // Fill, then an overflow push that must be dropped.
        for (int i = 0; i < 4; i++) do_push(fill_pc[i], fill_pred[i]);
        do_push(16'h0514, 1'b1);
        // Two correct resolves.
        do_resolve(1'b1);
        do_resolve(1'b0);
        idle();

        // Mispredict squash with a same-cycle wrong-path push.
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) do_push(fill_pc[i], fill_pred[i]);
        cycle(1'b1, 16'h0600, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        // Resolve while empty must produce nothing.
        do_resolve(1'b1);
        idle();

        // Full with push+resolve: push accepted, occupancy stays at DEPTH.
        for (int i = 0; i < 4; i++) do_push(fill_pc[i], fill_pred[i]);
        cycle(1'b1, 16'h0700, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // Flush with a correct resolve: one write, queue empty.
        cycle(1'b1, 16'h0800, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        idle();

        // Wrap-around: ten branches streamed through, each resolved correctly.
        do_push(16'h1000, 1'b0);
        for (int i = 1; i < 10; i++)
            cycle(1'b1, 16'(16'h1000 + i * 4), 1'(i % 2), 1'b1, 1'((i - 1) % 2), 1'b0, 1'b0);
        do_resolve(1'b1);
        idle();

        // Five mispredicts, then reset with three entries pending.
        for (int i = 0; i < 5; i++) begin
            do_push(16'(16'h2000 + i), 1'b1);
            do_resolve(1'b0);
        end
        for (int i = 0; i < 3; i++) do_push(16'(16'h3000 + i), 1'b0);
        cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("midreset_write_enabled", 32'(write_enabled), 32'd0);
        check("midreset_outcome", 32'(outcome), 32'd0);
        check("midreset_pc_bits_write", 32'(pc_bits_write), 32'd0);
        check("midreset_mispredict", 32'(mispredict), 32'd0);
        do_push(16'h0ABC, 1'b1);
        do_resolve(1'b1);
        idle();

        // Randomized traffic, including occasional flushes and resets.
        for (int n = 0; n < 3000; n++) begin
            cycle(1'($urandom_range(0, 99) < 60), 16'($urandom), 1'($urandom),
                  1'($urandom_range(0, 99) < 45), 1'($urandom_range(0, 99) < 70),
                  1'($urandom_range(0, 99) < 4), 1'($urandom_range(0, 299) == 0));
        end
        idle();
        idle();
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
Name: branch_update_queue

Overview:
- In-order queue of in-flight conditional branches between fetch and execute.
- Fetch pushes each predicted branch: PC plus the prediction from bimodal_predictor.
- Execute resolves branches oldest-first. The block pops the head, drives the predictor's training write port (write_enabled, outcome, pc_bits_write) and flags mispredictions.
- On a mispredict it discards all younger wrong-path entries.

Parameters:
- DEPTH, 4, number of queue entries; power of two, 2..16.
- PC_WIDTH, 16, branch PC width; matches the predictor PC ports.
- CNT_WIDTH, 16, width of the saturating mispredict counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- push  input  1  fetch enqueues a branch this cycle.
- push_pc  input  PC_WIDTH  PC of the pushed branch.
- push_pred  input  1  prediction issued for the pushed branch (1 = taken).
- resolve  input  1  execute resolves the oldest in-flight branch this cycle.
- resolve_taken  input  1  actual direction of the resolved branch.
- flush  input  1  external pipeline flush (exception/redirect); discards all entries.
- full  output  1  occupancy == DEPTH (combinational from state).
- empty  output  1  occupancy == 0 (combinational from state).
- occupancy  output  $clog2(DEPTH)+1  current entry count.
- write_enabled  output  1  registered; predictor training strobe.
- outcome  output  1  registered; actual direction for training.
- pc_bits_write  output  PC_WIDTH  registered; PC of the trained branch.
- mispredict  output  1  registered; one-cycle pulse when the resolved prediction was wrong.
- mispredict_count  output  CNT_WIDTH  saturating count of mispredicts since reset.

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, pred}, with head/tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
- Reset (synchronous, reset high at the rising edge):
  - Pointers, occupancy and mispredict_count go to 0.
  - write_enabled, outcome, mispredict go to 0; pc_bits_write goes to 0.
  - Reset overrides push, resolve and flush in the same cycle. Reset mid-operation discards all entries.
- Valid events:
  - push is accepted only when !full, or when full && a valid resolve occurs the same cycle (the pop frees a slot).
  - push while full without a valid resolve is dropped; the state is unchanged.
  - resolve is valid only when !empty. A resolve while empty is ignored: no write, no mispredict, no counter change.
  - A push into an empty queue in the same cycle as resolve: the push is accepted and the resolve is ignored. The new entry is never resolved in its own push cycle.
- Valid resolve in cycle N:
  - In cycle N+1: write_enabled=1, outcome=resolve_taken, pc_bits_write=head.pc. These are held one cycle only.
  - Misprediction is defined as resolve_taken != head.pred. In that case mispredict=1 in cycle N+1, and mispredict_count increments, saturating at 2^CNT_WIDTH-1.
  - Correct prediction: head pops normally. Simultaneous push and pop leaves occupancy unchanged.
  - Misprediction: head pops and all younger entries are discarded (tail=head+1, occupancy=0). A push in the same cycle is dropped, because it is wrong-path.
- Cycles with no valid resolve: write_enabled=0 and mispredict=0 in the following cycle.
- flush in cycle N:
  - Occupancy becomes 0 and tail=head at N+1. A push in the same cycle is dropped.
  - A valid resolve in the same cycle is still honoured: the training write and mispredict/counter behave as normal at N+1, before the queue is emptied.
  - If flush and a mispredicting resolve coincide, the queue ends empty with a single mispredict pulse.
- Latency: push to resolvable is 1 cycle; resolve to predictor write is 1 cycle; resolve to mispredict is 1 cycle.
- Ordering: entries are strictly FIFO and never reordered.

Test Plan:
- Reset then fill: push pc 0x0104, 0x0208, 0x030C, 0x0410 (pred 1,0,1,1) -> full=1, occupancy=4. A 5th push of 0x0514 is dropped; occupancy stays 4.
- Correct resolves: from the full state above, resolve_taken 1,0 on consecutive cycles -> write_enabled pulses with pc_bits_write 0x0104 then 0x0208 and outcome 1 then 0; mispredict=0; occupancy=2.
- Mispredict squash: queue holds 0x0104(pred 1), 0x0208, 0x030C; resolve_taken=0 with push of 0x0600 in the same cycle -> next cycle write_enabled=1, pc_bits_write=0x0104, outcome=0, mispredict=1, mispredict_count=1, occupancy=0, empty=1. 0x0600 is not stored.
- Wrap-around: push/resolve 10 branches through DEPTH=4 with pointers wrapping -> training writes appear in push order with the correct PCs; occupancy never exceeds 4.
- Boundaries: resolve while empty -> no write_enabled. Full with push+resolve in the same cycle -> push accepted, occupancy stays 4. Flush together with a correct resolve -> one training write, queue empty.
- Reset mid-stream: occupancy 3, mispredict_count 5, assert reset -> next cycle all outputs 0, empty=1, mispredict_count=0. A push after reset is stored at entry 0.
